// File: rtl/cond_flag_unit.sv
// NZCV flag register and condition evaluator.
// Gates the decoder's write/branch enables with the condition result.
module cond_flag_unit #(
  parameter int NFLAGS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InstrValid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [3:0]        Cond,
  input  logic [NFLAGS-1:0] ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
  output logic              CondExQ,
  output logic [3:0]        Flags
);

  logic live;
  logic n, z, c, v;

  assign live = InstrValid & ~Flush & ~Stall & ~reset;
  assign {n, z, c, v} = Flags;

  // Evaluated against the held flags only; no same-cycle bypass.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = ~(n ^ v);
      4'b1011: CondEx = n ^ v;
      4'b1100: CondEx = ~z & ~(n ^ v);
      4'b1101: CondEx = z | (n ^ v);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  // live is ANDed last so an X condition on a dead slot resolves to 0.
  assign PCSrc    = PCS  & CondEx & live;
  assign RegWrite = RegW & CondEx & live;
  assign MemWrite = MemW & CondEx & live;

  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else if (live && CondEx) begin
      if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || Flush) begin
      CondExQ <= 1'b0;
    end else if (!Stall) begin
      CondExQ <= CondEx & live;
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed and randomized checks of cond_flag_unit
// against a small behavioural flag model.
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       InstrValid;
  logic       Stall;
  logic       Flush;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic       CondExQ;
  logic [3:0] Flags;

  int checks = 0;
  int errors = 0;

  // model state
  logic [3:0] m_flags;
  logic       m_q;

  cond_flag_unit dut (
    .clk(clk), .reset(reset), .InstrValid(InstrValid),
    .Stall(Stall), .Flush(Flush), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS),
    .RegW(RegW), .MemW(MemW), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CondEx(CondEx), .CondExQ(CondExQ), .Flags(Flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic vld,
                       input logic stl, input logic fls,
                       input logic [3:0] cnd, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pcs,
                       input logic rw, input logic mw);
    reset = rst; InstrValid = vld; Stall = stl; Flush = fls;
    Cond = cnd; ALUFlags = alu; FlagW = fw;
    PCS = pcs; RegW = rw; MemW = mw;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Even codes are base predicates, odd codes their complement;
  // AL's complement is the reserved never-execute code.
  function automatic logic pass(input logic [3:0] cnd,
                                input logic [3:0] f);
    logic fn, fz, fc, fv, base;
    {fn, fz, fc, fv} = f;
    case (cnd[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc && !fz;
      3'd5: base = (fn == fv);
      3'd6: base = !fz && (fn == fv);
      default: base = 1'b1;
    endcase
    return cnd[0] ? !base : base;
  endfunction

  initial begin
    logic rst, vld, stl, fls, pcs, rw, mw, ok, go, cx;
    logic [3:0] cnd, alu;
    logic [1:0] fw;

    drive(1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
    tick();
    tick();

    // reset state, EQ fails on zero flags
    drive(0, 1, 0, 0, 4'b0000, 4'h0, 2'b00, 0, 1, 0);
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_q", {3'b0, CondExQ}, 4'b0000);
    chk("eq_condex", {3'b0, CondEx}, 4'b0000);
    chk("eq_regwrite", {3'b0, RegWrite}, 4'b0000);
    drive(0, 1, 0, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 0);
    chk("al_regwrite", {3'b0, RegWrite}, 4'b0001);
    tick();

    // full flag write, then read-after-write
    drive(0, 1, 0, 0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0);
    tick();
    chk("fw11_flags", Flags, 4'b0100);
    drive(0, 1, 0, 0, 4'b0000, 4'h0, 2'b00, 0, 0, 1);
    chk("raw_memwrite", {3'b0, MemWrite}, 4'b0001);
    drive(0, 1, 0, 0, 4'b0001, 4'h0, 2'b00, 0, 0, 1);
    chk("ne_condex", {3'b0, CondEx}, 4'b0000);
    chk("ne_memwrite", {3'b0, MemWrite}, 4'b0000);

    // C,V half only
    drive(0, 1, 0, 0, 4'b1110, 4'b1011, 2'b01, 0, 0, 0);
    tick();
    chk("fw01_flags", Flags, 4'b0111);
    drive(0, 1, 0, 0, 4'b1000, 4'h0, 2'b00, 0, 0, 0);
    chk("hi_condex", {3'b0, CondEx}, 4'b0000);
    drive(0, 1, 0, 0, 4'b1010, 4'h0, 2'b00, 0, 0, 0);
    chk("ge_condex", {3'b0, CondEx}, 4'b0000);
    drive(0, 1, 0, 0, 4'b1101, 4'h0, 2'b00, 0, 0, 0);
    chk("le_condex", {3'b0, CondEx}, 4'b0001);

    // failed condition never writes flags
    drive(1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 4'b0000, 4'b1111, 2'b11, 1, 1, 1);
    chk("fail_enables", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    tick();
    chk("fail_flags", Flags, 4'b0000);
    chk("fail_q", {3'b0, CondExQ}, 4'b0000);

    // stall holds, release writes, flush squashes
    drive(0, 1, 0, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0);
    tick();
    chk("q_set", {3'b0, CondExQ}, 4'b0001);
    drive(0, 1, 1, 0, 4'b1110, 4'b1010, 2'b11, 1, 0, 0);
    chk("stall_pcsrc", {3'b0, PCSrc}, 4'b0000);
    chk("stall_condex", {3'b0, CondEx}, 4'b0001);
    tick();
    chk("stall_flags", Flags, 4'b0000);
    chk("stall_q", {3'b0, CondExQ}, 4'b0001);
    drive(0, 1, 0, 0, 4'b1110, 4'b1010, 2'b11, 1, 0, 0);
    chk("unstall_pcsrc", {3'b0, PCSrc}, 4'b0001);
    tick();
    chk("unstall_flags", Flags, 4'b1010);
    drive(0, 1, 0, 1, 4'b1110, 4'b0101, 2'b11, 1, 0, 0);
    chk("flush_pcsrc", {3'b0, PCSrc}, 4'b0000);
    tick();
    chk("flush_flags", Flags, 4'b1010);
    chk("flush_q", {3'b0, CondExQ}, 4'b0000);

    // reset beats a same-edge flag write
    drive(0, 1, 0, 0, 4'b1110, 4'b1111, 2'b11, 0, 0, 0);
    tick();
    chk("set_all_flags", Flags, 4'b1111);
    drive(1, 1, 0, 0, 4'b1110, 4'b0000, 2'b11, 0, 1, 0);
    chk("rst_regwrite", {3'b0, RegWrite}, 4'b0000);
    tick();
    chk("rst_mid_flags", Flags, 4'b0000);
    chk("rst_mid_q", {3'b0, CondExQ}, 4'b0000);
    drive(0, 1, 0, 0, 4'b1111, 4'h0, 2'b00, 1, 1, 1);
    chk("nv_condex", {3'b0, CondEx}, 4'b0000);
    chk("nv_enables", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);

    // randomized against the model
    drive(1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
    tick();
    m_flags = 4'b0000;
    m_q = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 29) == 0);
      vld = ($urandom_range(0, 3) != 0);
      stl = ($urandom_range(0, 4) == 0);
      fls = ($urandom_range(0, 5) == 0);
      cnd = 4'($urandom);
      alu = 4'($urandom);
      fw  = 2'($urandom);
      pcs = 1'($urandom);
      rw  = 1'($urandom);
      mw  = 1'($urandom);
      drive(rst, vld, stl, fls, cnd, alu, fw, pcs, rw, mw);
      if (!vld && $urandom_range(0, 1) == 1) begin
        Cond = 4'bxxxx;
        #1;
      end
      go = vld && !stl && !fls && !rst;
      cx = !$isunknown(Cond) && pass(Cond, m_flags);
      ok = go && cx;
      if (!$isunknown(Cond))
        chk("rnd_condex", {3'b0, CondEx}, {3'b0, cx});
      chk("rnd_enables", {1'b0, PCSrc, RegWrite, MemWrite},
          {1'b0, pcs && ok, rw && ok, mw && ok});
      tick();
      if (rst) begin
        m_flags = 4'b0000;
        m_q = 1'b0;
      end else begin
        if (ok && fw[1]) m_flags[3:2] = alu[3:2];
        if (ok && fw[0]) m_flags[1:0] = alu[1:0];
        if (fls) m_q = 1'b0;
        else if (!stl) m_q = ok;
      end
      chk("rnd_flags", Flags, m_flags);
      chk("rnd_q", {3'b0, CondExQ}, {3'b0, m_q});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer end of the ALU flag interface.
- Holds the architectural NZCV flag register.
- Evaluates each instruction's 4-bit condition field against the held flags, then gates the decoder's write and branch enables with the result.
- Writes new flags from the ALU flag bus when the instruction passes its condition and requests a flag update.
- Sits between the main decoder/ALU and the register file, memory write port and PC mux.

Parameters:
- NFLAGS, 4, width of the ALU flag bus in {N,Z,C,V} order (bit 3 = N, bit 0 = V); fixed at 4 and not overridable in practice.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- InstrValid  input  1  the current-cycle Cond/FlagW/enables belong to a real instruction.
- Stall  input  1  pipeline hold; blocks flag update and gates all enables off.
- Flush  input  1  squash the current instruction; treated as InstrValid=0.
- Cond  input  4  instruction condition field.
- ALUFlags  input  NFLAGS  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  input  2  [1] requests an N,Z update; [0] requests a C,V update.
- PCS  input  1  decoder branch/PC-write request.
- RegW  input  1  decoder register-file write request.
- MemW  input  1  decoder memory write request.
- PCSrc  output  1  gated PCS.
- RegWrite  output  1  gated RegW.
- MemWrite  output  1  gated MemW.
- CondEx  output  1  combinational condition result for the current instruction.
- CondExQ  output  1  CondEx registered for multicycle controllers.
- Flags  output  4  current architectural flag register {N,Z,C,V}.

Behaviour:
- Live = InstrValid & ~Flush & ~Stall & ~reset.
- CondEx is evaluated from the registered Flags (pre-update value), combinationally, in the same cycle as Cond:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (reserved, never executes)
- Gated enables are combinational, zero added latency:
  - PCSrc = PCS & CondEx & Live
  - RegWrite = RegW & CondEx & Live
  - MemWrite = MemW & CondEx & Live
- Flag write:
  - On the clk edge with Live & CondEx & FlagW[1], Flags[3:2] <= ALUFlags[3:2].
  - On the clk edge with Live & CondEx & FlagW[0], Flags[1:0] <= ALUFlags[1:0].
  - Each half updates independently; an unwritten half holds.
- Read-after-write: an instruction in cycle t+1 sees flags written at the end of cycle t. There is no bypass of ALUFlags into CondEx within the same cycle.
- CondExQ <= CondEx & Live each edge. It holds its value while Stall=1 and is cleared by Flush.
- Stall=1: flags and CondExQ hold; PCSrc, RegWrite and MemWrite are 0. CondEx still reflects Cond for observability.
- Flush=1 (with or without Stall): no flag write; gated enables 0; CondExQ <= 0.
- Reset:
  - On a clk edge with reset=1: Flags <= 4'b0000, CondExQ <= 0.
  - While reset=1, PCSrc, RegWrite and MemWrite are 0 combinationally.
  - Reset asserted mid-instruction discards that instruction's flag write; reset has priority over all other inputs.
- Flags are never modified when CondEx=0, even if FlagW is nonzero.
- X on Cond while InstrValid=0 must not propagate to the gated outputs.

Test Plan:
- Reset, then Cond=0000 (EQ), InstrValid=1, RegW=1 → Flags=0000, CondEx=0, RegWrite=0. Next: Cond=1110, RegW=1 → RegWrite=1.
- Cond=1110, FlagW=11, ALUFlags=0100 → Flags=0100 after one edge. Next cycle Cond=0000, MemW=1 → MemWrite=1. Same-cycle Cond=0001 → CondEx=0.
- Flags=0100, then Cond=1110, FlagW=01, ALUFlags=1011 → Flags=0111 (N,Z preserved, C,V updated). Then Cond=1000 (HI) → CondEx=0; Cond=1010 (GE) with N=0, V=1 → CondEx=0; Cond=1101 (LE) → CondEx=1.
- Flags=0000, Cond=0000 (fails), FlagW=11, ALUFlags=1111 → Flags remain 0000, all gated enables 0, CondExQ=0.
- Stall=1 with Cond=1110, FlagW=11, ALUFlags=1010, PCS=1 → PCSrc=0, Flags unchanged, CondExQ held. Deassert Stall → PCSrc=1, Flags=1010 next edge. Repeat with Flush=1 → no update, CondExQ=0.
- Flags=1111 with Cond=1110, FlagW=11, ALUFlags=0000, reset=1 on the same edge → Flags=0000, RegWrite=0 during reset. Cond=1111 after reset → CondEx=0 regardless of flags.
